// File: rtl/kyber_pkg.sv
// Shared constants and FSM state type for the Kyber butterfly sweep engine.
// No ports; imported by ntt_ram and kyber_ntt_top.
package kyber_pkg;

   localparam int KYBER_Q    = 3329;
   localparam int KYBER_ZETA = 17;
   localparam int KYBER_N    = 256;
   localparam int KYBER_AW   = $clog2(KYBER_N);

   typedef enum logic [2:0] {
      IDLE,
      RD_U,
      RD_V,
      LATCH,
      CALC,
      WR_U,
      WR_V,
      DONE
   } state_e;

endpackage

// File: rtl/ntt_ram.sv
// Single-port coefficient RAM, N x 16 bits, synchronous read (one-cycle
// latency) and synchronous write.
// Ports:
//   clk   - clock
//   we    - write enable
//   addr  - word address
//   wdata - write data
//   rdata - read data, valid the cycle after addr is presented
// Contents are deliberately not reset so coefficients survive a block reset.
module ntt_ram
   import kyber_pkg::*;
#(
   parameter int N  = KYBER_N,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [15:0]   wdata,
   output logic [15:0]   rdata
);

   logic [15:0] ram [N];
   logic [15:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we) begin
         ram[addr] <= wdata;
      end
      rdata_q <= ram[addr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/kyber_ntt_top.sv
// Kyber butterfly sweep: walks pairs (ram[2k], ram[2k+1]) for k = 0..N/2-1,
// replacing each with (u+t) mod Q and (u-t) mod Q, where u = U mod Q and
// t = V*ZETA mod Q.
// Ports:
//   clk          - clock
//   rst          - asynchronous active-low reset
//   start        - one-cycle sweep request, accepted in IDLE or DONE only
//   done         - high once a sweep completes, until the next accepted start
//   result_check - upper result of pair 0 from the most recent sweep
//
// state | meaning
// IDLE  | waiting for start after reset
// RD_U  | address 2k presented to RAM
// RD_V  | address 2k+1 presented, U captured
// LATCH | V captured
// CALC  | both butterfly results registered
// WR_U  | ram[2k] written
// WR_V  | ram[2k+1] written, advance k or finish
// DONE  | sweep complete, waiting for start
module kyber_ntt_top
   import kyber_pkg::*;
#(
   parameter int Q    = KYBER_Q,
   parameter int ZETA = KYBER_ZETA,
   parameter int N    = KYBER_N
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        done,
   output logic [15:0] result_check
);

   localparam int AW = $clog2(N);
   localparam int KW = AW - 1;
   localparam logic [KW-1:0] K_LAST = KW'(N/2 - 1);

   state_e        state_q, state_d;
   logic [KW-1:0] k_q, k_d;
   logic [15:0]   u_q, u_d;
   logic [15:0]   v_q, v_d;
   logic [15:0]   res_u_q, res_u_d;
   logic [15:0]   res_v_q, res_v_d;
   logic [15:0]   result_check_q, result_check_d;

   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [15:0]   ram_wdata;
   logic [15:0]   ram_rdata;

   logic [31:0]   u_mod, v_prod, t_mod, sum_mod, diff_mod;

   ntt_ram #(.N(N), .AW(AW)) memory (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: if (start) state_d = RD_U;
         RD_U:       state_d = RD_V;
         RD_V:       state_d = LATCH;
         LATCH:      state_d = CALC;
         CALC:       state_d = WR_U;
         WR_U:       state_d = WR_V;
         WR_V:       state_d = (k_q == K_LAST) ? DONE : RD_U;
         default:    state_d = IDLE;
      endcase
   end

   always_comb begin
      done      = (state_q == DONE);
      ram_we    = (state_q == WR_U) || (state_q == WR_V);
      ram_addr  = {k_q, (state_q == RD_V) || (state_q == WR_V)};
      ram_wdata = (state_q == WR_V) ? res_v_q : res_u_q;
   end

   // 32-bit intermediates: V*ZETA needs 21 bits for 16-bit V; raw U may exceed Q.
   always_comb begin
      u_mod   = 32'(u_q) % 32'(Q);
      v_prod  = 32'(v_q) * 32'(ZETA);
      t_mod   = v_prod % 32'(Q);
      sum_mod = u_mod + t_mod;
      if (sum_mod >= 32'(Q)) begin
         sum_mod = sum_mod - 32'(Q);
      end
      diff_mod = (u_mod < t_mod) ? (u_mod + 32'(Q) - t_mod) : (u_mod - t_mod);
   end

   always_comb begin
      k_d            = k_q;
      u_d            = u_q;
      v_d            = v_q;
      res_u_d        = res_u_q;
      res_v_d        = res_v_q;
      result_check_d = result_check_q;
      case (state_q)
         IDLE, DONE: if (start) k_d = '0;
         RD_V:       u_d = ram_rdata;
         LATCH:      v_d = ram_rdata;
         CALC: begin
            res_u_d = 16'(sum_mod);
            res_v_d = 16'(diff_mod);
         end
         WR_U:       if (k_q == '0) result_check_d = res_u_q;
         WR_V:       if (k_q != K_LAST) k_d = k_q + KW'(1);
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         k_q            <= '0;
         u_q            <= '0;
         v_q            <= '0;
         res_u_q        <= '0;
         res_v_q        <= '0;
         result_check_q <= '0;
      end else begin
         k_q            <= k_d;
         u_q            <= u_d;
         v_q            <= v_d;
         res_u_q        <= res_u_d;
         res_v_q        <= res_v_d;
         result_check_q <= result_check_d;
      end
   end

   assign result_check = result_check_q;

endmodule

// File: tb/tb_kyber_ntt_top.sv
module tb_kyber_ntt_top;

   localparam int Q     = 3329;
   localparam int ZETA  = 17;
   localparam int N     = 256;
   localparam int NP    = N / 2;
   localparam int SWEEP = 6 * NP;

   logic        clk   = 1'b0;
   logic        rst   = 1'b1;
   logic        start = 1'b0;
   logic        done;
   logic [15:0] result_check;

   int checks = 0;
   int errors = 0;
   int model_mem [N];
   int n;

   kyber_ntt_top #(.Q(Q), .ZETA(ZETA), .N(N)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .done         (done),
      .result_check (result_check)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference butterfly on the first npairs pairs, straight from the modular definition.
   task automatic model_pairs(input int npairs);
      for (int k = 0; k < npairs; k++) begin
         int u, t;
         u = model_mem[2*k] % Q;
         t = (model_mem[2*k+1] * ZETA) % Q;
         model_mem[2*k]   = (u + t) % Q;
         model_mem[2*k+1] = (u - t + Q) % Q;
      end
   endtask

   task automatic push_model();
      for (int i = 0; i < N; i++) dut.memory.ram[i] = 16'(model_mem[i]);
   endtask

   task automatic clear_model();
      for (int i = 0; i < N; i++) model_mem[i] = 0;
   endtask

   task automatic check_ram(input string tag);
      for (int i = 0; i < N; i++)
         check($sformatf("%s_ram%0d", tag, i), 32'(dut.memory.ram[i]), 32'(model_mem[i]));
   endtask

   task automatic run_sweep(input string tag, input int mid_start, output int cycles);
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      check({tag, "_done_clr"}, 32'(done), 32'(0));
      cycles = 0;
      while (cycles < 2000) begin
         @(posedge clk);
         cycles++;
         #1;
         if (done) break;
         start = (cycles == mid_start);
      end
      start = 1'b0;
      check({tag, "_latency"}, 32'(cycles), 32'(SWEEP));
   endtask

   initial begin
      clear_model();
      model_mem[0] = 100;
      model_mem[1] = 200;
      push_model();
      #2 rst = 1'b0;
      #1;
      check("reset_done", 32'(done), 32'(0));
      check("reset_rc", 32'(result_check), 32'(0));
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (5) @(negedge clk);
      check("idle_wait_done", 32'(done), 32'(0));

      // Basic 100/200 sweep
      model_pairs(NP);
      run_sweep("basic", -1, n);
      check("basic_u0", 32'(dut.memory.ram[0]), 32'(171));
      check("basic_v0", 32'(dut.memory.ram[1]), 32'(29));
      check("basic_rc", 32'(result_check), 32'(171));
      check_ram("basic");
      repeat (5) @(posedge clk);
      #1 check("done_held", 32'(done), 32'(1));

      // Second sweep on persisted contents, with an ignored start mid-sweep
      model_pairs(NP);
      run_sweep("second", 100, n);
      check("second_u0", 32'(dut.memory.ram[0]), 32'(664));
      check("second_v0", 32'(dut.memory.ram[1]), 32'(3007));
      check("second_rc", 32'(result_check), 32'(664));
      check_ram("second");

      // Wrap and borrow boundaries
      clear_model();
      model_mem[0] = 3328;
      model_mem[1] = 1;
      model_mem[2] = 0;
      model_mem[3] = 1;
      push_model();
      model_pairs(NP);
      run_sweep("bound", -1, n);
      check("wrap_u", 32'(dut.memory.ram[0]), 32'(16));
      check("wrap_v", 32'(dut.memory.ram[1]), 32'(3311));
      check("borrow_u", 32'(dut.memory.ram[2]), 32'(17));
      check("borrow_v", 32'(dut.memory.ram[3]), 32'(3312));
      check("bound_rc", 32'(result_check), 32'(16));
      check_ram("bound");

      // Random full-range 16-bit contents
      for (int i = 0; i < N; i++) model_mem[i] = int'($urandom_range(0, 65535));
      push_model();
      model_pairs(NP);
      run_sweep("rand", -1, n);
      check("rand_rc", 32'(result_check), 32'(model_mem[0]));
      check_ram("rand");

      // Reset during a sweep, just after pair 49 has been written
      for (int i = 0; i < N; i++) model_mem[i] = int'($urandom_range(0, 65535));
      push_model();
      @(negedge clk) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (300) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("midrst_done", 32'(done), 32'(0));
      check("midrst_rc", 32'(result_check), 32'(0));
      model_pairs(50);
      check_ram("midrst");
      @(negedge clk) rst = 1'b1;
      repeat (4) @(negedge clk);
      check("midrst_idle", 32'(done), 32'(0));
      check("midrst_ram_hold", 32'(dut.memory.ram[100]), 32'(model_mem[100]));
      model_pairs(NP);
      run_sweep("afterrst", -1, n);
      check("afterrst_rc", 32'(result_check), 32'(model_mem[0]));
      check_ram("afterrst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
